start_debounce_arm: RTL

- Upstream stage for the microsecond delay counter. Its registered `start` level drives the counter's `start` input, and the counter's `out` returns here as `done`.
- Synchronizes and debounces a raw push-button, then arms the delay (`start`=1) on a debounced press.
- Drops `start` when the delay expires or the button is pressed again (cancel). Optionally re-arms automatically on expiry.

---
 rtl/delay_pkg.sv | 19 +
 rtl/start_debounce_arm_if.sv | 30 +++
 rtl/btn_debounce.sv | 75 +++++++
 rtl/start_debounce_arm.sv | 84 ++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared definitions for the push-button arm stage and the microsecond delay counter.
// Holds the arm FSM state type and clock-rate defaults.
package delay_pkg;

  localparam int unsigned ClockSpeedMhzDefault = 12;
  localparam int unsigned UsPerMs              = 1000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESTART
  } arm_state_t;

  // Counter width for a counter that wraps at n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/start_debounce_arm_if.sv
// Button/done inputs and arm/status outputs of the start_debounce_arm stage.
// The slave modport is the stage itself; master is whoever drives the button and done.
interface start_debounce_arm_if;

  logic btn;
  logic done;
  logic start;
  logic btn_level;
  logic pressed;
  logic expired;

  modport master (
    output btn,
    output done,
    input  start,
    input  btn_level,
    input  pressed,
    input  expired
  );

  modport slave (
    input  btn,
    input  done,
    output start,
    output btn_level,
    output pressed,
    output expired
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, microsecond prescaler and debounce counter for a raw button pin.
// btn_level_o is the accepted level (1 = pressed); pressed_o pulses on each accepted press.
module btn_debounce
  import delay_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED_MHZ   = ClockSpeedMhzDefault,
  parameter int unsigned DEBOUNCE_US       = 10 * UsPerMs,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn_i,
  output logic btn_level_o,
  output logic pressed_o,
  output logic us_tick_o
);

  localparam int unsigned PrescW = cnt_width(CLOCK_SPEED_MHZ);
  localparam int unsigned DebW   = cnt_width(DEBOUNCE_US);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(CLOCK_SPEED_MHZ - 1);
  localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_US - 1);

  logic              sync1_q, sync2_q;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [DebW-1:0]   cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              pressed_q, pressed_d;
  logic              btn_act;
  logic              us_tick;

  assign btn_act = sync2_q ^ BUTTON_ACTIVE_LOW;
  assign us_tick = (presc_q == PrescLast);

  always_comb begin
    presc_d   = us_tick ? '0 : presc_q + 1'b1;
    cnt_d     = cnt_q;
    level_d   = level_q;
    pressed_d = 1'b0;
    if (btn_act == level_q) begin
      cnt_d = '0;
    end else if (us_tick) begin
      if (cnt_q == DebLast) begin
        level_d   = btn_act;
        pressed_d = btn_act;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sync flops reset to the released pin level so reset never looks like a press.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q   <= BUTTON_ACTIVE_LOW;
      sync2_q   <= BUTTON_ACTIVE_LOW;
      presc_q   <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pressed_q <= pressed_d;
    end
  end

  assign btn_level_o = level_q;
  assign pressed_o   = pressed_q;
  assign us_tick_o   = us_tick;

endmodule

// File: rtl/start_debounce_arm.sv
// Arms the downstream delay counter on a debounced button press and drops the arm on
// expiry or a cancelling press; optionally re-arms after a one-cycle clear on expiry.
module start_debounce_arm
  import delay_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED_MHZ   = ClockSpeedMhzDefault,
  parameter int unsigned DEBOUNCE_US       = 10 * UsPerMs,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1,
  parameter bit          REPEAT            = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  start_debounce_arm_if.slave  bus
);

  arm_state_t state_q, state_d;
  logic       start_q, start_d;
  logic       expired_q, expired_d;
  logic       done_blk_q, done_blk_d;
  logic       btn_level;
  logic       pressed;
  logic       us_tick;
  logic       accept;
  logic       unused_us_tick;

  btn_debounce #(
    .CLOCK_SPEED_MHZ  (CLOCK_SPEED_MHZ),
    .DEBOUNCE_US      (DEBOUNCE_US),
    .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
  ) u_debounce (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .btn_i      (bus.btn),
    .btn_level_o(btn_level),
    .pressed_o  (pressed),
    .us_tick_o  (us_tick)
  );

  assign unused_us_tick = us_tick;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pressed) state_d = RUN;
      end
      RUN: begin
        // done_blk_q masks a done level that was already consumed.
        if (bus.done && !done_blk_q) begin
          accept  = 1'b1;
          state_d = REPEAT ? RESTART : IDLE;
        end else if (pressed) begin
          state_d = IDLE;
        end
      end
      RESTART: state_d = RUN;
      default: state_d = IDLE;
    endcase
    done_blk_d = bus.done & (done_blk_q | accept);
    start_d    = (state_d == RUN);
    expired_d  = accept;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      expired_q  <= 1'b0;
      done_blk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      expired_q  <= expired_d;
      done_blk_q <= done_blk_d;
    end
  end

  assign bus.start     = start_q;
  assign bus.expired   = expired_q;
  assign bus.btn_level = btn_level;
  assign bus.pressed   = pressed;

endmodule
